// File: rtl/mips_wb_trace_monitor_if.sv
// Write-event taps from the mips core plus the valid/ready event stream and
// status counters of the trace monitor.
interface mips_wb_trace_monitor_if;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_type;
  logic [31:0] out_pc;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        overflow;
  logic [31:0] event_cnt;
  logic [7:0]  drop_cnt;

  // Monitor side: taps and ready in, stream and status out.
  modport slave (
    input  grf_we, grf_pc, grf_addr, grf_data,
    input  dm_we, dm_pc, dm_addr, dm_data,
    input  out_ready,
    output out_valid, out_type, out_pc, out_addr, out_data,
    output overflow, event_cnt, drop_cnt
  );

  // Core/consumer side.
  modport master (
    output grf_we, grf_pc, grf_addr, grf_data,
    output dm_we, dm_pc, dm_addr, dm_data,
    output out_ready,
    input  out_valid, out_type, out_pc, out_addr, out_data,
    input  overflow, event_cnt, drop_cnt
  );
endinterface

// File: rtl/mips_wb_trace_monitor.sv
// Captures GRF/DM write events into a show-ahead FIFO and streams them out
// one per valid/ready handshake; counts accepted and dropped events.
module mips_wb_trace_monitor #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AW          = 3,
  parameter int unsigned FILTER_ZERO = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_wb_trace_monitor_if.slave    mon
);

  localparam int unsigned OW = AW + 1;
  localparam int unsigned FW = AW + 2;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic          overflow_q;
  logic [31:0]   event_cnt_q;
  logic [7:0]    drop_cnt_q;

  logic        mem_type [DEPTH];
  logic [31:0] mem_pc   [DEPTH];
  logic [31:0] mem_addr [DEPTH];
  logic [31:0] mem_data [DEPTH];

  logic          g, d, pop, push_g, push_d;
  logic [FW-1:0] free;
  logic [1:0]    n_push, n_drop;
  logic [AW-1:0] dm_slot;
  logic [8:0]    drop_sum;

  // Push/drop decision: a pop frees its slot this edge, GRF has priority.
  always_comb begin
    g        = mon.grf_we && !((FILTER_ZERO != 0) && (mon.grf_addr == 5'd0));
    d        = mon.dm_we;
    pop      = (occ != '0) && mon.out_ready;
    free     = FW'(DEPTH) - FW'(occ) + FW'(pop);
    push_g   = g && (free >= FW'(1));
    push_d   = d && ((FW'(g) + FW'(d)) <= free);
    n_push   = 2'(push_g) + 2'(push_d);
    n_drop   = 2'(g) + 2'(d) - n_push;
    dm_slot  = wr_ptr + AW'(push_g);
    drop_sum = 9'(drop_cnt_q) + 9'(n_drop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      overflow_q  <= 1'b0;
      event_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr      <= wr_ptr + AW'(n_push);
      rd_ptr      <= rd_ptr + AW'(pop);
      occ         <= occ + OW'(n_push) - OW'(pop);
      event_cnt_q <= event_cnt_q + 32'(n_push);
      if (n_drop != 2'd0) overflow_q <= 1'b1;
      drop_cnt_q  <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end
  end

  // Storage is not reset; the empty mask on the outputs hides stale entries.
  always_ff @(posedge clk) begin
    if (push_g) begin
      mem_type[wr_ptr] <= 1'b0;
      mem_pc[wr_ptr]   <= mon.grf_pc;
      mem_addr[wr_ptr] <= {27'd0, mon.grf_addr};
      mem_data[wr_ptr] <= mon.grf_data;
    end
    if (push_d) begin
      mem_type[dm_slot] <= 1'b1;
      mem_pc[dm_slot]   <= mon.dm_pc;
      mem_addr[dm_slot] <= mon.dm_addr;
      mem_data[dm_slot] <= mon.dm_data;
    end
  end

  always_comb begin
    mon.out_valid = 1'b0;
    mon.out_type  = 1'b0;
    mon.out_pc    = '0;
    mon.out_addr  = '0;
    mon.out_data  = '0;
    if (occ != '0) begin
      mon.out_valid = 1'b1;
      mon.out_type  = mem_type[rd_ptr];
      mon.out_pc    = mem_pc[rd_ptr];
      mon.out_addr  = mem_addr[rd_ptr];
      mon.out_data  = mem_data[rd_ptr];
    end
  end

  assign mon.overflow  = overflow_q;
  assign mon.event_cnt = event_cnt_q;
  assign mon.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mips_wb_trace_monitor.sv
// Bench for mips_wb_trace_monitor: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mips_wb_trace_monitor;

  localparam int unsigned DEPTH = 8;

  typedef struct {
    logic        t;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic clk;
  logic reset;
  mips_wb_trace_monitor_if ifc ();

  mips_wb_trace_monitor #(.DEPTH(8), .AW(3), .FILTER_ZERO(1)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (ifc)
  );

  int checks = 0;
  int errors = 0;

  ev_t         q[$];
  int unsigned m_ev;
  int          m_drop;
  bit          m_ovf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each edge, pop the head if accepted, then push in GRF-then-DM order while space remains.
  always @(posedge clk) begin : model
    int  free, acc, drops;
    bit  g, d;
    ev_t e;
    if (reset) begin
      if (q.size() != 0 && ifc.out_ready) void'(q.pop_front());
      g = ifc.grf_we && (ifc.grf_addr != 5'd0);
      d = ifc.dm_we;
      free = DEPTH - q.size();
      acc = 0;
      if (int'(g) + int'(d) <= free) begin
        if (g) begin
          e.t = 1'b0; e.pc = ifc.grf_pc; e.addr = {27'd0, ifc.grf_addr}; e.data = ifc.grf_data;
          q.push_back(e); acc++;
        end
        if (d) begin
          e.t = 1'b1; e.pc = ifc.dm_pc; e.addr = ifc.dm_addr; e.data = ifc.dm_data;
          q.push_back(e); acc++;
        end
      end else if (g && free >= 1) begin
        e.t = 1'b0; e.pc = ifc.grf_pc; e.addr = {27'd0, ifc.grf_addr}; e.data = ifc.grf_data;
        q.push_back(e); acc++;
      end
      drops = int'(g) + int'(d) - acc;
      m_ev = m_ev + acc;
      if (drops > 0) m_ovf = 1'b1;
      m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    end
  end

  // Every-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    chk("out_valid", ifc.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_type", ifc.out_type, q[0].t);
      chk("out_pc", ifc.out_pc, q[0].pc);
      chk("out_addr", ifc.out_addr, q[0].addr);
      chk("out_data", ifc.out_data, q[0].data);
    end else begin
      chk("empty_mask", {ifc.out_type, ifc.out_pc, ifc.out_addr, ifc.out_data} != '0, 0);
    end
    chk("event_cnt", ifc.event_cnt, m_ev);
    chk("drop_cnt", ifc.drop_cnt, m_drop);
    chk("overflow", ifc.overflow, m_ovf);
  end

  task automatic idle();
    ifc.grf_we = 1'b0; ifc.grf_pc = '0; ifc.grf_addr = '0; ifc.grf_data = '0;
    ifc.dm_we  = 1'b0; ifc.dm_pc  = '0; ifc.dm_addr  = '0; ifc.dm_data  = '0;
  endtask

  // Let one rising edge happen, return just after the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic model_clear();
    q.delete();
    m_ev = 0; m_drop = 0; m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    #1;
    reset = 1'b1;
  endtask

  task automatic grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] dt);
    ifc.grf_we = 1'b1; ifc.grf_pc = pc; ifc.grf_addr = a; ifc.grf_data = dt;
  endtask

  task automatic dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] dt);
    ifc.dm_we = 1'b1; ifc.dm_pc = pc; ifc.dm_addr = a; ifc.dm_data = dt;
  endtask

  task automatic rand_inputs(input int we_pct, input int rdy_pct);
    idle();
    if ($urandom_range(0, 99) < we_pct)
      grf($urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
    if ($urandom_range(0, 99) < we_pct)
      dm($urandom, $urandom, $urandom);
    ifc.out_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  initial begin : main
    int cnt;
    reset = 1'b0;
    model_clear();
    idle();
    ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", ifc.out_valid, 0);
    chk("rst_event_cnt", ifc.event_cnt, 0);
    reset = 1'b1;

    // 1: single GRF write, visible after one edge, popped on the next
    ifc.out_ready = 1'b1;
    grf(32'h3000, 5'd8, 32'h1234);
    step();
    idle();
    chk("t1_valid", ifc.out_valid, 1);
    chk("t1_type", ifc.out_type, 0);
    chk("t1_pc", ifc.out_pc, 32'h3000);
    chk("t1_addr", ifc.out_addr, 32'h8);
    chk("t1_data", ifc.out_data, 32'h1234);
    step();
    chk("t1_popped", ifc.out_valid, 0);
    chk("t1_event_cnt", ifc.event_cnt, 1);

    // 2: write to $0 is filtered
    do_reset();
    grf(32'h3004, 5'd0, 32'hFFFF);
    step();
    idle();
    chk("t2_valid", ifc.out_valid, 0);
    chk("t2_event_cnt", ifc.event_cnt, 0);
    chk("t2_overflow", ifc.overflow, 0);

    // 3: simultaneous GRF and DM, GRF first
    do_reset();
    ifc.out_ready = 1'b0;
    grf(32'h3008, 5'd2, 32'd5);
    dm(32'h3008, 32'h10, 32'd7);
    step();
    idle();
    chk("t3_first_type", ifc.out_type, 0);
    chk("t3_first_data", ifc.out_data, 5);
    chk("t3_event_cnt", ifc.event_cnt, 2);
    ifc.out_ready = 1'b1;
    step();
    chk("t3_second_type", ifc.out_type, 1);
    chk("t3_second_addr", ifc.out_addr, 32'h10);
    chk("t3_second_data", ifc.out_data, 7);
    step();
    chk("t3_empty", ifc.out_valid, 0);

    // 4: ten stores into an 8-deep FIFO with no consumer
    do_reset();
    ifc.out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      idle();
      dm(32'h4000 + 32'(i), 32'h100 + 32'(4 * i), 32'(i));
      step();
    end
    idle();
    chk("t4_overflow", ifc.overflow, 1);
    chk("t4_drop_cnt", ifc.drop_cnt, 2);
    chk("t4_event_cnt", ifc.event_cnt, 8);
    ifc.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t4_drain_data", ifc.out_data, 32'(i));
      step();
    end
    chk("t4_drained", ifc.out_valid, 0);

    // 5: full FIFO, pop and push on the same edge
    do_reset();
    ifc.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idle();
      dm(32'h5000, 32'h200, 32'(i));
      step();
    end
    idle();
    ifc.out_ready = 1'b1;
    grf(32'h5100, 5'd9, 32'hABCD);
    step();
    idle();
    ifc.out_ready = 1'b0;
    chk("t5_drop_cnt", ifc.drop_cnt, 0);
    chk("t5_event_cnt", ifc.event_cnt, 9);
    chk("t5_head", ifc.out_data, 2);
    ifc.out_ready = 1'b1;
    cnt = 0;
    while (ifc.out_valid && cnt < 20) begin
      cnt++;
      step();
    end
    chk("t5_occupancy", cnt, 8);

    // 6: reset pulsed mid-cycle with entries buffered
    do_reset();
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      grf(32'h6000 + 32'(4 * i), 5'(i + 1), 32'(100 + i));
      step();
    end
    idle();
    chk("t6_buffered", ifc.out_valid, 1);
    reset = 1'b0;
    model_clear();
    #1;
    chk("t6_valid_async", ifc.out_valid, 0);
    chk("t6_event_cnt", ifc.event_cnt, 0);
    chk("t6_overflow", ifc.overflow, 0);
    chk("t6_drop_cnt", ifc.drop_cnt, 0);
    reset = 1'b1;
    grf(32'h6100, 5'd3, 32'h77);
    step();
    idle();
    chk("t6_post_valid", ifc.out_valid, 1);
    chk("t6_post_data", ifc.out_data, 32'h77);

    // Random: heavy load with a slow consumer, then balanced traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(70, 25);
      step();
    end
    idle();
    chk("rand_drop_saturated", ifc.drop_cnt, 255);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(40, 70);
      if ($urandom_range(0, 299) == 0) do_reset();
      step();
    end
    idle();
    ifc.out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("final_empty", ifc.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_wb_trace_monitor.md
Name: mips_wb_trace_monitor

Overview:
- Observer on the CPU's architectural write side. It captures GRF and DM write events from the mips core and buffers them in a FIFO.
- It presents the events one at a time on a valid/ready stream to a consumer: the bench checker or a later UART dumper.
- This block carries results out of the core; the clk/reset stimulus drives the core in.
- It sits beside mips and taps the core's write-enable, address, data and PC signals without modifying them.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of two and at least 2.
- AW, 3: log2(DEPTH), the pointer width.
- FILTER_ZERO, 1: when 1, GRF writes to register $0 are discarded and not counted.

Ports:
- clk  in  1  rising-edge clock shared with mips.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- grf_we  in  1  GRF write strobe, sampled at rising edge.
- grf_pc  in  32  PC of the writing instruction.
- grf_addr  in  5  destination register.
- grf_data  in  32  written value.
- dm_we  in  1  DM write strobe, sampled at rising edge.
- dm_pc  in  32  PC of the store.
- dm_addr  in  32  byte address.
- dm_data  in  32  stored word.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head when out_valid=1 at a rising edge.
- out_type  out  1  0 = GRF event, 1 = DM event.
- out_pc  out  32  event PC.
- out_addr  out  32  register number zero-extended, or memory address.
- out_data  out  32  event data.
- overflow  out  1  sticky: at least one event was dropped.
- event_cnt  out  32  count of events accepted into the FIFO (wraps at 2^32).
- drop_cnt  out  8  dropped events; saturates at 255.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers, occupancy, overflow, event_cnt and drop_cnt all go to 0.
  - out_valid=0; out_type/pc/addr/data read 0 until the first push.
  - FIFO storage need not be cleared; outputs are masked to 0 while empty.
- Event qualification, per rising edge:
  - g = grf_we && !(FILTER_ZERO && grf_addr==0).
  - d = dm_we.
- Pop: pop = out_valid && out_ready.
- Free space this edge: free = DEPTH - occ + pop. A pop frees its slot for a push on the same edge.
- Push order on the same edge:
  - The GRF event takes the lower slot, then the DM event; pushes are written at wr_ptr and wr_ptr+1.
  - Needed slots n = g + d.
  - If n <= free: all n are pushed.
  - If n > free: the GRF event is pushed if free >= 1 and the DM event is dropped. If free = 0, both are dropped.
- Each dropped event sets overflow=1 and increments drop_cnt (saturating). event_cnt increments by the number pushed.
- Next state: occ_next = occ + pushed - pop. Pointers wrap modulo DEPTH.
- Output timing:
  - Show-ahead: out_* reflect mem[rd_ptr] combinationally from registered state.
  - out_valid = (occ != 0).
  - An event sampled at edge N is visible on out_* after edge N, a latency of 1 cycle when the FIFO was empty.
- Stream stability: while out_valid=1 and out_ready=0, out_* hold stable until popped.
- Full FIFO with out_ready=1: the pop and the push happen on the same edge, with no drop when n=1.
- out_ready while out_valid=0 is ignored.
- Reset asserted mid-stream discards all buffered events. The first post-reset event appears exactly as from empty.
- overflow and drop_cnt clear only on reset.

Test Plan:
1. Reset low, then one grf_we with pc=0x3000, addr=8, data=0x1234, out_ready=1.
   - Required: one cycle later out_valid=1, type=0, addr=0x8, data=0x1234.
   - Popped next edge; event_cnt=1.
2. grf_we to addr=0 with data=0xFFFF, FILTER_ZERO=1.
   - Required: out_valid stays 0, event_cnt=0, overflow=0.
3. Same edge: grf (addr=2, data=5) and dm (addr=0x10, data=7).
   - Required: two entries, GRF first then DM (type 1, addr 0x10); event_cnt=2.
4. out_ready=0 and 10 sequential DM stores with data 1..10, DEPTH=8.
   - Required: 8 stored, overflow=1, drop_cnt=2.
   - Draining yields data 1..8 in order.
5. FIFO full, out_ready=1, one grf_we on the same edge.
   - Required: accepted, occupancy stays 8, drop_cnt unchanged.
6. Three entries buffered, then reset pulsed low mid-cycle.
   - Required: out_valid drops to 0 immediately; counters and overflow read 0.
